// File: rtl/ub_controller_if.sv
// rtl/ub_controller_if.sv - command, accumulator-flag and buffer-strobe bundle for ub_controller
interface ub_controller_if #(
   parameter int ADDR_W = 13,
   parameter int CNT_W  = 5
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_op;
   logic [ADDR_W-1:0] cmd_base;
   logic [CNT_W-1:0]  cmd_count;
   logic              store_acc1;
   logic              store_acc2;
   logic              acc_ack;
   logic [ADDR_W-1:0] ub_addr;
   logic              ub_store;
   logic              ub_load;
   logic              load_valid;
   logic              busy;
   logic              done;
   logic              cmd_err;

   modport slave (
      input  cmd_valid, cmd_op, cmd_base, cmd_count, store_acc1, store_acc2,
      output cmd_ready, acc_ack, ub_addr, ub_store, ub_load, load_valid, busy, done, cmd_err
   );

   modport master (
      output cmd_valid, cmd_op, cmd_base, cmd_count, store_acc1, store_acc2,
      input  cmd_ready, acc_ack, ub_addr, ub_store, ub_load, load_valid, busy, done, cmd_err
   );
endinterface

// File: rtl/ub_controller.sv
// rtl/ub_controller.sv - tile sequencer for the unified buffer (store from accumulators, load to input setup)
module ub_controller #(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 13,
   parameter int CNT_W  = 5
) (
   input  logic           clk,
   input  logic           reset,
   ub_controller_if.slave bus
);
   localparam int EXT_W = ADDR_W + 3;

   typedef enum logic [2:0] {IDLE, S_WAIT, S_GAP, L_ISSUE, FIN} state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] cur_addr_q;
   logic [ADDR_W-1:0] ub_addr_q;
   logic [CNT_W-1:0]  remaining_q;
   logic              busy_q;
   logic              done_q;
   logic              cmd_err_q;
   logic              load_valid_q;

   logic [EXT_W-1:0]  end_addr;
   logic              cmd_bad;
   logic              store_fire;
   logic              load_fire;
   logic              last_tile;
   logic [ADDR_W-1:0] next_addr_d;

   // End address is widened so an oversize command cannot wrap into range.
   assign end_addr    = {3'b000, bus.cmd_base} + (EXT_W'(bus.cmd_count) << 2);
   assign cmd_bad     = (bus.cmd_count == '0) || (bus.cmd_base[1:0] != 2'b00)
                        || (end_addr > EXT_W'(DEPTH));
   assign store_fire  = (state_q == S_WAIT) && bus.store_acc1 && bus.store_acc2;
   assign load_fire   = (state_q == L_ISSUE);
   assign last_tile   = (remaining_q == CNT_W'(1));
   assign next_addr_d = cur_addr_q + ADDR_W'(4);

   assign bus.cmd_ready  = (state_q == IDLE);
   assign bus.ub_store   = store_fire;
   assign bus.acc_ack    = store_fire;
   assign bus.ub_load    = load_fire;
   assign bus.ub_addr    = ub_addr_q;
   assign bus.load_valid = load_valid_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.cmd_err    = cmd_err_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         cur_addr_q   <= '0;
         ub_addr_q    <= '0;
         remaining_q  <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         cmd_err_q    <= 1'b0;
         load_valid_q <= 1'b0;
      end else begin
         done_q       <= 1'b0;
         cmd_err_q    <= 1'b0;
         load_valid_q <= load_fire;
         case (state_q)
            IDLE: begin
               if (bus.cmd_valid) begin
                  if (cmd_bad) begin
                     cmd_err_q <= 1'b1;
                  end else begin
                     cur_addr_q  <= bus.cmd_base;
                     ub_addr_q   <= bus.cmd_base;
                     remaining_q <= bus.cmd_count;
                     busy_q      <= 1'b1;
                     state_q     <= bus.cmd_op ? L_ISSUE : S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (store_fire) begin
                  cur_addr_q  <= next_addr_d;
                  ub_addr_q   <= next_addr_d;
                  remaining_q <= remaining_q - CNT_W'(1);
                  if (last_tile) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= FIN;
                  end else begin
                     state_q <= S_GAP;
                  end
               end
            end
            // Gives the accumulators a cycle to drop their full flags after acc_ack.
            S_GAP: begin
               state_q <= S_WAIT;
            end
            L_ISSUE: begin
               cur_addr_q  <= next_addr_d;
               ub_addr_q   <= next_addr_d;
               remaining_q <= remaining_q - CNT_W'(1);
               if (last_tile) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= FIN;
               end
            end
            FIN: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end
endmodule
